// File: rtl/rd_edge_range_bram_if.sv
// rd_edge_range_bram_if
//   Per-core bus between the active-vertex scheduler, the BRAM read stage and
//   the edge-fetch stage. Every vector carries CORE_NUM lanes, with lane i in
//   slice i.
//   Front side (scheduler -> stage): front_rd_edge_addr, front_push_flag,
//     front_active_v_id, front_active_v_value, front_rd_edge_valid,
//     front_iteration_end, front_iteration_end_valid.
//   Back side: next_stage_full (downstream stall into the stage); stage_full
//     (upstream stall out of the stage); result outputs push_flag,
//     active_v_id, active_v_value, active_v_edge, active_v_edge_end,
//     active_v_valid, iteration_end, iteration_end_valid, overflow_err.
//   Modports: slave = the read stage; master = the environment that drives
//   the front side and consumes the results.
interface rd_edge_range_bram_if #(
  parameter int unsigned CORE_NUM      = 8,
  parameter int unsigned AWIDTH        = 11,
  parameter int unsigned V_ID_WIDTH    = 32,
  parameter int unsigned V_VALUE_WIDTH = 32,
  parameter int unsigned DWIDTH        = 32
);
  logic [CORE_NUM*AWIDTH-1:0]        front_rd_edge_addr;
  logic [CORE_NUM-1:0]               front_push_flag;
  logic [CORE_NUM*V_ID_WIDTH-1:0]    front_active_v_id;
  logic [CORE_NUM*V_VALUE_WIDTH-1:0] front_active_v_value;
  logic [CORE_NUM-1:0]               front_rd_edge_valid;
  logic [CORE_NUM-1:0]               front_iteration_end;
  logic [CORE_NUM-1:0]               front_iteration_end_valid;
  logic [CORE_NUM-1:0]               next_stage_full;
  logic [CORE_NUM-1:0]               stage_full;
  logic [CORE_NUM-1:0]               push_flag;
  logic [CORE_NUM*V_ID_WIDTH-1:0]    active_v_id;
  logic [CORE_NUM*V_VALUE_WIDTH-1:0] active_v_value;
  logic [CORE_NUM*DWIDTH-1:0]        active_v_edge;
  logic [CORE_NUM*DWIDTH-1:0]        active_v_edge_end;
  logic [CORE_NUM-1:0]               active_v_valid;
  logic [CORE_NUM-1:0]               iteration_end;
  logic [CORE_NUM-1:0]               iteration_end_valid;
  logic [CORE_NUM-1:0]               overflow_err;

  modport master (
    output front_rd_edge_addr, front_push_flag, front_active_v_id, front_active_v_value,
           front_rd_edge_valid, front_iteration_end, front_iteration_end_valid, next_stage_full,
    input  stage_full, push_flag, active_v_id, active_v_value, active_v_edge, active_v_edge_end,
           active_v_valid, iteration_end, iteration_end_valid, overflow_err
  );

  modport slave (
    input  front_rd_edge_addr, front_push_flag, front_active_v_id, front_active_v_value,
           front_rd_edge_valid, front_iteration_end, front_iteration_end_valid, next_stage_full,
    output stage_full, push_flag, active_v_id, active_v_value, active_v_edge, active_v_edge_end,
           active_v_valid, iteration_end, iteration_end_valid, overflow_err
  );
endinterface

// File: rtl/rd_edge_range_bram.sv
// rd_edge_range_bram
//   Per-core BRAM read stage of the BFS pipeline. For each accepted request
//   it looks up the CSR offset of the active vertex: mem[addr] and, when
//   MODE_RANGE is set, also mem[addr+1]. The sideband fields (push_flag,
//   v_id, v_value, iteration_end) travel alongside the lookup in request
//   order. A per-core skid FIFO absorbs downstream back-pressure.
//   Ports: clk, rst_n (asynchronous, active-low); bus (slave modport of
//   rd_edge_range_bram_if: the front requests, the stalls and the results);
//   init_wr_en/core/addr/data form the offset-table load port.
module rd_edge_range_bram #(
  parameter int unsigned CORE_NUM       = 8,
  parameter int unsigned CORE_NUM_WIDTH = 3,
  parameter int unsigned V_ID_WIDTH     = 32,
  parameter int unsigned V_VALUE_WIDTH  = 32,
  parameter int unsigned AWIDTH         = 11,
  parameter int unsigned DWIDTH         = 32,
  parameter int unsigned RD_LAT         = 2,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned MODE_RANGE     = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  rd_edge_range_bram_if.slave       bus,
  input  logic                      init_wr_en,
  input  logic [CORE_NUM_WIDTH-1:0] init_wr_core,
  input  logic [AWIDTH-1:0]         init_wr_addr,
  input  logic [DWIDTH-1:0]         init_wr_data
);
  localparam int unsigned DEPTH = 2**AWIDTH;
  localparam int unsigned PW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;

  typedef struct packed {
    logic                     push_flag;
    logic [V_ID_WIDTH-1:0]    v_id;
    logic [V_VALUE_WIDTH-1:0] v_value;
    logic                     rd_valid;
    logic                     iter_end;
    logic                     iter_end_valid;
  } side_t;

  typedef struct packed {
    side_t             side;
    logic [DWIDTH-1:0] first_edge;
    logic [DWIDTH-1:0] end_edge;
  } entry_t;

  logic [DWIDTH-1:0] mem       [CORE_NUM][DEPTH];
  logic [RD_LAT-1:0] pipe_v    [CORE_NUM];
  side_t             pipe_side [CORE_NUM][RD_LAT];
  logic [DWIDTH-1:0] pipe_a    [CORE_NUM][RD_LAT];
  logic [DWIDTH-1:0] pipe_b    [CORE_NUM][RD_LAT];
  entry_t            fifo_mem  [CORE_NUM][FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr    [CORE_NUM];
  logic [PW-1:0]     rd_ptr    [CORE_NUM];
  logic [CW-1:0]     fifo_cnt  [CORE_NUM];
  logic [CW-1:0]     inflight  [CORE_NUM];
  entry_t            out_q     [CORE_NUM];
  logic [AWIDTH-1:0] addr_a    [CORE_NUM];
  logic [AWIDTH-1:0] addr_b    [CORE_NUM];
  side_t             in_side   [CORE_NUM];

  logic [CORE_NUM-1:0] req, acc, push, pop, full;
  logic [CORE_NUM-1:0] out_rd_v, out_end_v, ovf;

  // Credits count FIFO entries plus reads still in the BRAM pipe, so every
  // accepted request has a FIFO slot reserved by the time it emerges.
  always_comb begin
    for (int unsigned i = 0; i < CORE_NUM; i++) begin
      addr_a[i]  = bus.front_rd_edge_addr[i*AWIDTH +: AWIDTH];
      addr_b[i]  = addr_a[i] + AWIDTH'(1);
      in_side[i] = '{push_flag:      bus.front_push_flag[i],
                     v_id:           bus.front_active_v_id[i*V_ID_WIDTH +: V_ID_WIDTH],
                     v_value:        bus.front_active_v_value[i*V_VALUE_WIDTH +: V_VALUE_WIDTH],
                     rd_valid:       bus.front_rd_edge_valid[i],
                     iter_end:       bus.front_iteration_end[i],
                     iter_end_valid: bus.front_iteration_end_valid[i]};
      req[i]      = bus.front_rd_edge_valid[i] | bus.front_iteration_end_valid[i];
      inflight[i] = '0;
      for (int unsigned s = 0; s < RD_LAT; s++) inflight[i] = inflight[i] + CW'(pipe_v[i][s]);
      full[i] = ((fifo_cnt[i] + inflight[i]) >= CW'(FIFO_DEPTH - 1))
              | (init_wr_en & (init_wr_core == CORE_NUM_WIDTH'(i)));
      acc[i]  = req[i] & ~full[i];
      push[i] = pipe_v[i][RD_LAT-1];
      pop[i]  = (fifo_cnt[i] != '0) & ~bus.next_stage_full[i];
    end
  end

  // Table storage, BRAM data pipe and FIFO storage carry no reset; only the
  // valid/pointer state below is cleared, so reset discards queued entries.
  always_ff @(posedge clk) begin
    if (init_wr_en) mem[init_wr_core][init_wr_addr] <= init_wr_data;
    for (int unsigned i = 0; i < CORE_NUM; i++) begin
      pipe_side[i][0] <= in_side[i];
      pipe_a[i][0]    <= mem[i][addr_a[i]];
      pipe_b[i][0]    <= (MODE_RANGE != 0) ? mem[i][addr_b[i]] : '0;
      for (int unsigned s = 1; s < RD_LAT; s++) begin
        pipe_side[i][s] <= pipe_side[i][s-1];
        pipe_a[i][s]    <= pipe_a[i][s-1];
        pipe_b[i][s]    <= pipe_b[i][s-1];
      end
      if (push[i])
        fifo_mem[i][wr_ptr[i]] <= '{side:       pipe_side[i][RD_LAT-1],
                                    first_edge: pipe_a[i][RD_LAT-1],
                                    end_edge:   pipe_b[i][RD_LAT-1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < CORE_NUM; i++) begin
        pipe_v[i]   <= '0;
        wr_ptr[i]   <= '0;
        rd_ptr[i]   <= '0;
        fifo_cnt[i] <= '0;
        out_q[i]    <= '0;
      end
      out_rd_v  <= '0;
      out_end_v <= '0;
      ovf       <= '0;
    end else begin
      for (int unsigned i = 0; i < CORE_NUM; i++) begin
        pipe_v[i][0] <= acc[i];
        for (int unsigned s = 1; s < RD_LAT; s++) pipe_v[i][s] <= pipe_v[i][s-1];
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
        if (pop[i]) begin
          rd_ptr[i] <= rd_ptr[i] + PW'(1);
          out_q[i]  <= fifo_mem[i][rd_ptr[i]];
        end
        fifo_cnt[i]  <= fifo_cnt[i] + CW'(push[i]) - CW'(pop[i]);
        out_rd_v[i]  <= pop[i] & fifo_mem[i][rd_ptr[i]].side.rd_valid;
        out_end_v[i] <= pop[i] & fifo_mem[i][rd_ptr[i]].side.iter_end_valid;
        if (req[i] & full[i]) ovf[i] <= 1'b1;
      end
    end
  end

  always_comb begin
    bus.stage_full          = full;
    bus.active_v_valid      = out_rd_v;
    bus.iteration_end_valid = out_end_v;
    bus.overflow_err        = ovf;
    bus.push_flag           = '0;
    bus.iteration_end       = '0;
    bus.active_v_id         = '0;
    bus.active_v_value      = '0;
    bus.active_v_edge       = '0;
    bus.active_v_edge_end   = '0;
    for (int unsigned i = 0; i < CORE_NUM; i++) begin
      bus.push_flag[i]     = out_q[i].side.push_flag;
      bus.iteration_end[i] = out_q[i].side.iter_end;
      bus.active_v_id[i*V_ID_WIDTH +: V_ID_WIDTH]          = out_q[i].side.v_id;
      bus.active_v_value[i*V_VALUE_WIDTH +: V_VALUE_WIDTH] = out_q[i].side.v_value;
      bus.active_v_edge[i*DWIDTH +: DWIDTH]                = out_q[i].first_edge;
      bus.active_v_edge_end[i*DWIDTH +: DWIDTH]            = out_q[i].end_edge;
    end
  end
endmodule

// File: tb/tb_rd_edge_range_bram.sv
module tb_rd_edge_range_bram;
  localparam int unsigned CN  = 8;
  localparam int unsigned CNW = 3;
  localparam int unsigned VIW = 32;
  localparam int unsigned VVW = 32;
  localparam int unsigned AW  = 11;
  localparam int unsigned DW  = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic           init_wr_en = 1'b0;
  logic [CNW-1:0] init_wr_core = '0;
  logic [AW-1:0]  init_wr_addr = '0;
  logic [DW-1:0]  init_wr_data = '0;

  always #5 clk = ~clk;

  rd_edge_range_bram_if #(.CORE_NUM(CN), .AWIDTH(AW), .V_ID_WIDTH(VIW),
                          .V_VALUE_WIDTH(VVW), .DWIDTH(DW)) bus ();

  rd_edge_range_bram #(.CORE_NUM(CN), .CORE_NUM_WIDTH(CNW), .V_ID_WIDTH(VIW),
                       .V_VALUE_WIDTH(VVW), .AWIDTH(AW), .DWIDTH(DW), .RD_LAT(2),
                       .FIFO_DEPTH(8), .MODE_RANGE(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .init_wr_en(init_wr_en), .init_wr_core(init_wr_core),
    .init_wr_addr(init_wr_addr), .init_wr_data(init_wr_data)
  );

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  typedef struct {
    int lane; int addr; int vid; int val;
    bit pf; bit rdv; bit ie; bit iev; bit chk_data;
    int exp_edge; int exp_end;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_front();
    bus.front_rd_edge_addr        = '0;
    bus.front_push_flag           = '0;
    bus.front_active_v_id         = '0;
    bus.front_active_v_value      = '0;
    bus.front_rd_edge_valid       = '0;
    bus.front_iteration_end       = '0;
    bus.front_iteration_end_valid = '0;
  endtask

  task automatic drive_lane(input int lane, input int addr, input int vid, input int val,
                            input bit pf, input bit rdv, input bit ie, input bit iev);
    bus.front_rd_edge_addr[lane*AW +: AW]     = AW'(addr);
    bus.front_active_v_id[lane*VIW +: VIW]    = VIW'(vid);
    bus.front_active_v_value[lane*VVW +: VVW] = VVW'(val);
    bus.front_push_flag[lane]                 = pf;
    bus.front_rd_edge_valid[lane]             = rdv;
    bus.front_iteration_end[lane]             = ie;
    bus.front_iteration_end_valid[lane]       = iev;
  endtask

  task automatic wr(input int core, input int addr, input int data, input bit chk);
    init_wr_en   = 1'b1;
    init_wr_core = CNW'(core);
    init_wr_addr = AW'(addr);
    init_wr_data = DW'(data);
    #1;
    if (chk) check("stage_full_during_init", 64'(bus.stage_full), 64'(8'h01 << core));
    @(posedge clk);
    #1;
    init_wr_en = 1'b0;
  endtask

  function automatic logic [DW-1:0] edge_of(input int lane);
    return bus.active_v_edge[lane*DW +: DW];
  endfunction
  function automatic logic [DW-1:0] edge_end_of(input int lane);
    return bus.active_v_edge_end[lane*DW +: DW];
  endfunction
  function automatic logic [VIW-1:0] vid_of(input int lane);
    return bus.active_v_id[lane*VIW +: VIW];
  endfunction
  function automatic logic [VVW-1:0] val_of(input int lane);
    return bus.active_v_value[lane*VVW +: VVW];
  endfunction

  initial begin
    int acc;
    int got;
    int seen;

    // lane addr vid val pf rdv ie iev chk_data exp_edge exp_end
    vecs[0] = '{0,    0, 10, 1, 0, 1, 0, 0, 1,  1,  7};
    vecs[1] = '{3,    3, 33, 5, 1, 1, 0, 0, 1,  4, 10};
    vecs[2] = '{7,    7, 77, 9, 0, 1, 0, 0, 1,  8, 14};
    vecs[3] = '{5,    5, 55, 2, 0, 1, 1, 1, 1,  6, 12};
    vecs[4] = '{2,    2, 22, 3, 0, 0, 1, 1, 0,  0,  0};
    vecs[5] = '{0, 2047, 99, 4, 0, 1, 0, 0, 1, 32'hABCD, 1};

    clear_front();
    bus.next_stage_full = '0;

    // Reset held for 10 cycles
    repeat (10) step();
    check("rst_valid", 64'(bus.active_v_valid), 64'h0);
    check("rst_end_valid", 64'(bus.iteration_end_valid), 64'h0);
    check("rst_ovf", 64'(bus.overflow_err), 64'h0);
    check("rst_edge", 64'(bus.active_v_edge[63:0]), 64'h0);
    rst_n = 1'b1;
    step();
    check("rst_stage_full", 64'(bus.stage_full), 64'h0);

    // Offset table load
    for (int i = 0; i < 8; i++) begin
      wr(i, i, i + 1, i == 3);
      wr(i, i + 1, i + 7, 1'b0);
    end
    wr(0, 2047, 32'hABCD, 1'b0);
    step();

    // All lanes at once, one request each
    for (int i = 0; i < 8; i++) drive_lane(i, i, i, 1, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    clear_front();
    step();
    step();
    check("all_lat_early", 64'(bus.active_v_valid), 64'h0);
    step();
    check("all_valid", 64'(bus.active_v_valid), 64'hFF);
    for (int i = 0; i < 8; i++) begin
      check("all_edge", 64'(edge_of(i)), 64'(i + 1));
      check("all_edge_end", 64'(edge_end_of(i)), 64'(i + 7));
      check("all_vid", 64'(vid_of(i)), 64'(i));
      check("all_val", 64'(val_of(i)), 64'h1);
    end
    step();
    check("all_pulse", 64'(bus.active_v_valid), 64'h0);

    // Table-driven single-lane vectors
    for (int v = 0; v < 6; v++) begin
      drive_lane(vecs[v].lane, vecs[v].addr, vecs[v].vid, vecs[v].val,
                 vecs[v].pf, vecs[v].rdv, vecs[v].ie, vecs[v].iev);
      step();
      clear_front();
      step();
      step();
      check("vec_early", 64'(bus.active_v_valid | bus.iteration_end_valid), 64'h0);
      step();
      check("vec_valid", 64'(bus.active_v_valid), 64'(vecs[v].rdv) << vecs[v].lane);
      check("vec_end_valid", 64'(bus.iteration_end_valid), 64'(vecs[v].iev) << vecs[v].lane);
      check("vec_vid", 64'(vid_of(vecs[v].lane)), 64'(vecs[v].vid));
      check("vec_val", 64'(val_of(vecs[v].lane)), 64'(vecs[v].val));
      check("vec_push_flag", 64'(bus.push_flag[vecs[v].lane]), 64'(vecs[v].pf));
      if (vecs[v].iev) check("vec_iter_end", 64'(bus.iteration_end[vecs[v].lane]), 64'(vecs[v].ie));
      if (vecs[v].chk_data) begin
        check("vec_edge", 64'(edge_of(vecs[v].lane)), 64'(vecs[v].exp_edge));
        check("vec_edge_end", 64'(edge_end_of(vecs[v].lane)), 64'(vecs[v].exp_end));
      end
      step();
      check("vec_pulse", 64'(bus.active_v_valid | bus.iteration_end_valid), 64'h0);
    end

    // Back-pressure on lane 1
    bus.next_stage_full = 8'h02;
    acc = 0;
    for (int c = 0; c < 20 && !bus.stage_full[1]; c++) begin
      drive_lane(1, 1, 100 + acc, 0, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
      acc++;
    end
    clear_front();
    check("bp_accepts", 64'(acc), 64'd7);
    check("bp_stage_full", 64'(bus.stage_full), 64'h02);
    check("bp_no_ovf", 64'(bus.overflow_err), 64'h0);

    // Request while full is dropped and flagged
    drive_lane(1, 1, 999, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    clear_front();
    check("ovf_set", 64'(bus.overflow_err), 64'h02);

    bus.next_stage_full = '0;
    got = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (bus.active_v_valid[1]) begin
        check("bp_order_vid", 64'(vid_of(1)), 64'(100 + got));
        check("bp_edge", 64'(edge_of(1)), 64'd2);
        got++;
      end
    end
    check("bp_out_count", 64'(got), 64'd7);
    check("ovf_sticky", 64'(bus.overflow_err), 64'h02);

    // Reset with three requests in flight
    for (int k = 0; k < 3; k++) begin
      drive_lane(0, 0, 50 + k, 0, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
    end
    clear_front();
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(bus.active_v_valid), 64'h0);
    check("async_rst_ovf", 64'(bus.overflow_err), 64'h0);
    step();
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if ((bus.active_v_valid | bus.iteration_end_valid) != '0) seen++;
    end
    check("no_out_after_rst", 64'(seen), 64'd0);
    check("post_rst_stage_full", 64'(bus.stage_full), 64'h0);

    // Table contents survive reset
    drive_lane(4, 4, 44, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    clear_front();
    step();
    step();
    step();
    check("mem_kept_valid", 64'(bus.active_v_valid), 64'h10);
    check("mem_kept_edge", 64'(edge_of(4)), 64'd5);
    check("mem_kept_edge_end", 64'(edge_end_of(4)), 64'd11);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
